udiv_iter: RTL and testbench

UDIV_ITER -- requirements
Module: udiv_iter

---
 rtl/udiv_iter.sv | 142 ++++++++++++++
 tb/tb_udiv_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/udiv_iter.sv
// udiv_iter: iterative unsigned restoring divider with optional round-half-up quotient.
// Latency: W+1 edges from accept to out_valid (divisor == 0: 1 edge); one operation in flight.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   in_valid/in_ready             operand handshake (dividend, divisor, rnd_mode)
//   out_valid/out_ready           result handshake (quotient, remainder, div_by_zero)
//   quotient/remainder            results; they keep their last values outside DONE
//   div_by_zero                   the latched divisor was zero
module udiv_iter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     pr_q, pr_d;      // partial remainder
  logic [W-1:0]   work_q, work_d;  // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [W-1:0]   dvs_q, dvs_d;
  logic           rnd_q, rnd_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [W:0]     trial;
  logic [W:0]     diff;
  logic           ge;
  logic [W-1:0]   rem_fin;
  logic [W:0]     twice;
  logic           rnd_up;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // One restoring step: shift the partial remainder left and bring in the next dividend MSB.
  assign trial   = (pr_q << 1) | {{W{1'b0}}, work_q[W-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign ge      = (trial >= {1'b0, dvs_q});

  // Round half up: 2*rem >= divisor, done at W+1 bits so the doubling cannot overflow.
  assign rem_fin = pr_q[W-1:0];
  assign twice   = {rem_fin, 1'b0};
  assign rnd_up  = rnd_q & (twice >= {1'b0, dvs_q});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      rnd_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      rnd_q   <= rnd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    rnd_d   = rnd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = dividend;
          dvs_d   = divisor;
          rnd_d   = rnd_mode;
          pr_d    = '0;
          // A zero divisor starts with an exhausted counter, so the very next
          // cycle is the finalise cycle and the result appears one edge later.
          cnt_d   = (divisor == '0) ? '0 : CW'(W);
          state_d = CALC;
        end
      end

      CALC: begin
        if (cnt_q != '0) begin
          pr_d   = ge ? diff : trial;
          work_d = {work_q[W-2:0], ge};
          cnt_d  = cnt_q - CW'(1);
        end else begin
          // Finalise cycle: register the result and present it.
          state_d = DONE;
          if (dvs_q == '0) begin
            quo_d = '1;
            rem_d = work_q;   // untouched dividend, no steps were taken
            dbz_d = 1'b1;
          end else begin
            // The rounded quotient never exceeds 2^W-1, so this cannot wrap.
            quo_d = work_q + {{(W-1){1'b0}}, rnd_up};
            rem_d = rem_fin;
            dbz_d = 1'b0;
          end
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udiv_iter.sv
// tb_udiv_iter: directed-vector bench for udiv_iter at W=24.
// Latency: measures accept-to-out_valid edges against hand-computed values.
// Backpressure: holds out_ready low to check that the result stays stable.
module tb_udiv_iter;

  localparam int W = 24;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk = 0;
  int n_err = 0;

  udiv_iter #(.W(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .rnd_mode   (rnd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands at a falling edge and hold them until the accepting rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    rnd_mode = r;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges after the accepting edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("done_vld", {31'd0, out_valid}, 32'd1);
  endtask

  // Full operation with out_ready high: checks latency, results and return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic r, input int exp_lat, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input logic exp_z);
    int lat;
    start_op(a, b, r);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, {8'd0, quotient}, {8'd0, exp_q});
    chk({tag, "_r"}, {8'd0, remainder}, {8'd0, exp_r});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
    @(posedge clk);
    #1;
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_q_held"}, {8'd0, quotient}, {8'd0, exp_q});
  endtask

  initial begin
    int lat;
    logic seen;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    rnd_mode  = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {8'd0, quotient}, 32'd0);
    chk("rst_r", {8'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic truncation and rounding vectors.
    run_op("d100_7",  24'd100, 24'd7, 1'b0, 25, 24'd14, 24'd2, 1'b0);
    run_op("d100_8r", 24'd100, 24'd8, 1'b1, 25, 24'd13, 24'd4, 1'b0);
    run_op("d99_8r",  24'd99,  24'd8, 1'b1, 25, 24'd12, 24'd3, 1'b0);
    run_op("d17_6r",  24'd17,  24'd6, 1'b1, 25, 24'd3,  24'd5, 1'b0);
    run_op("d17_6t",  24'd17,  24'd6, 1'b0, 25, 24'd2,  24'd5, 1'b0);
    run_op("d3_10",   24'd3,   24'd10, 1'b0, 25, 24'd0, 24'd3, 1'b0);
    run_op("d5_0",    24'd5,   24'd0, 1'b0, 1, 24'hFFFFFF, 24'd5, 1'b1);
    run_op("dmax_max", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 25, 24'd1, 24'd0, 1'b0);

    // Max dividend, rounding on, with backpressure held for 10 cycles.
    out_ready = 1'b0;
    start_op(24'hFFFFFF, 24'd1, 1'b1);
    wait_done(lat);
    chk("bp_lat", lat, 25);
    chk("bp_q", {8'd0, quotient}, 32'h00FFFFFF);
    chk("bp_r", {8'd0, remainder}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_q", {8'd0, quotient}, 32'h00FFFFFF);
      chk("bp_hold_r", {8'd0, remainder}, 32'd0);
      chk("bp_hold_dbz", {31'd0, div_by_zero}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_vld", {31'd0, out_valid}, 32'd0);
    chk("bp_rel_rdy", {31'd0, in_ready}, 32'd1);

    // Operands changed after accept must not affect the result: 200/9 = 22 r 2.
    start_op(24'd200, 24'd9, 1'b0);
    dividend = 24'd77;
    divisor  = 24'd5;
    rnd_mode = 1'b1;
    wait_done(lat);
    chk("chg_lat", lat, 25);
    chk("chg_q", {8'd0, quotient}, 32'd22);
    chk("chg_r", {8'd0, remainder}, 32'd2);
    @(posedge clk);
    #1;

    // Reset in the middle of a calculation aborts it.
    start_op(24'd1000, 24'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, in_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_q", {8'd0, quotient}, 32'd0);
    chk("mid_rst_r", {8'd0, remainder}, 32'd0);
    chk("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_result", {31'd0, seen}, 32'd0);
    run_op("d50_3", 24'd50, 24'd3, 1'b0, 25, 24'd16, 24'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
